sram_arb_ctl: RTL
=================

// Module: sram_arb_ctl
// PURPOSE
//  Shared asynchronous-SRAM controller with an N-channel request arbiter.
//  Lets IF (instruction fetch) and MEM (data) share one SRAM bank.
//  Each channel has its own ready/finish handshake, so channels no longer
//  drive shared status wires. Wait-state count and arbitration policy are
//  parameters.
// PARAMETERS
//  N_CH        2   number of requester channels (>=1); index width CW=max(1,$clog2(N_CH))
//  ADDR_W      20  SRAM word-address width
//  DATA_W      32  data width; multiple of 8; BE_W=DATA_W/8
//  WAIT_CYC    1   extra ACCESS cycles beyond the minimum one (0..15)
//  ARB_RR      1   1 = round-robin arbitration, 0 = fixed priority (channel 0 highest)
// PORTS
//  clk_i        in   1            clock; all logic on rising edge
//  rst_i        in   1            asynchronous, active-low reset
//  req_i        in   N_CH         per-channel request; held until that channel's response
//  rw_i         in   N_CH         per channel: 1 = read, 0 = write
//  addr_i       in   N_CH*ADDR_W  channel c occupies [c*ADDR_W +: ADDR_W]
//  wdata_i      in   N_CH*DATA_W  write data, packed per channel
//  be_n_i       in   N_CH*BE_W    byte enables, active low, packed per channel
//  rdata_o      out  DATA_W       last read data; held until the next read completes
//  r_ready_o    out  N_CH         one-cycle pulse: read data valid for channel c
//  w_finish_o   out  N_CH         one-cycle pulse: write done for channel c
//  grant_o      out  CW           index of the channel currently served
//  busy_o       out  1            high in any state other than IDLE
//  ram_addr_o   out  ADDR_W       SRAM address
//  ram_data_i   in   DATA_W       SRAM read data
//  ram_data_o   out  DATA_W       SRAM write data
//  ram_data_t_o out  1            1 = drive ram_data_o onto the bus; the top level builds the tristate
//  ram_be_n_o   out  BE_W         SRAM byte enables, active low
//  ram_ce_n_o   out  1            chip enable, active low
//  ram_oe_n_o   out  1            output enable, active low
//  ram_we_n_o   out  1            write enable, active low
// BEHAVIOUR
//  Reset (async, asserted low):
//   - FSM goes to IDLE; ce_n/oe_n/we_n = 1; be_n = all 1; data_t = 0.
//   - addr, data_o, rdata_o, grant_o = 0; all pulses 0; RR pointer = 0.
//   - Mid-transaction reset aborts it immediately. Strobes go inactive without
//     waiting for the clock, and no response is issued.
//  FSM: IDLE -> ACCESS -> (read) DONE | (write) HOLD -> DONE -> IDLE.
//  IDLE:
//   - When any req_i is high, pick a winner g and latch its rw, addr, wdata, be_n.
//   - Set grant_o=g and move to ACCESS. Nothing else happens in IDLE.
//  ACCESS: lasts WAIT_CYC+1 cycles, counted by a down-counter.
//   - ce_n=0 throughout; ram_addr_o and ram_be_n_o are stable.
//   - Read: oe_n=0, data_t=0. ram_data_i is registered into rdata_o on the final ACCESS cycle.
//   - Write: we_n=0, data_t=1, ram_data_o = latched wdata.
//  HOLD (write only, 1 cycle): we_n=1, ce_n=0, data_t=1. Address and data held (hold time).
//  DONE (1 cycle): strobes inactive, data_t=0.
//   - r_ready_o[g] or w_finish_o[g] = 1 for exactly this cycle. All other bits are 0.
//   - Next state is IDLE.
//  Latency from the req edge sampled in IDLE (cycle 0):
//   - read response in cycle WAIT_CYC+2; write response in cycle WAIT_CYC+3.
//   - Back-to-back issue rate: one transaction per WAIT_CYC+3 (read) or +4 (write) cycles.
//  Arbitration:
//   - ARB_RR=0: lowest index with req high wins.
//   - ARB_RR=1: search starts at ptr, wraps from N_CH-1 to 0. On grant, ptr = g+1 mod N_CH.
//   - N_CH=1: always grant 0.
//  Handshake:
//   - Requests are sampled only in IDLE.
//   - Dropping req mid-transaction does not cancel it; the response still pulses.
//   - A req still high in the IDLE after DONE is a new transaction.
//   - Inputs of the granted channel may change after the IDLE cycle (they are latched).
//  Simultaneous requests: exactly one channel is granted per IDLE cycle. Losers wait with req held.
//  busy_o = (state != IDLE), registered with the state.
// TESTING
//  1. Reset: rst_i=0 mid-ACCESS -> ce_n/we_n/oe_n=1 and data_t=0 without a clock edge;
//     after release, busy_o=0 and no response pulse.
//  2. Single read, WAIT_CYC=1: ch1 read addr 0x00010, SRAM model returns 0xDEADBEEF
//     -> oe_n low for 2 cycles; r_ready_o=2'b10 in cycle 3; rdata_o=0xDEADBEEF.
//  3. Byte write: ch0 write addr 0x00004, data 0x11223344, be_n=4'b1100
//     -> we_n low 2 cycles, then HOLD; w_finish_o=2'b01 in cycle 4;
//     SRAM word = 0xXXXX3344 (upper bytes unchanged).
//  4. Contention, ARB_RR=1: both channels hold reads continuously -> grants alternate
//     0,1,0,1; each response pulses only its own channel bit.
//  5. Fixed priority, ARB_RR=0: same stimulus -> channel 0 is granted every time while its req stays high.
//  6. Early drop: ch0 read, req_i[0] dropped in cycle 1 -> transaction completes;
//     r_ready_o[0] still pulses in cycle 3; FSM then stays in IDLE.

Source files
------------

// File: rtl/sram_arb_ctl.sv
// sram_arb_ctl: N-channel arbitrated controller for one asynchronous SRAM bank
module sram_arb_ctl #(
    parameter  int N_CH     = 2,
    parameter  int ADDR_W   = 20,
    parameter  int DATA_W   = 32,
    parameter  int WAIT_CYC = 1,
    parameter  int ARB_RR   = 1,
    localparam int BE_W     = DATA_W / 8,
    localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          req_i,
    input  logic [N_CH-1:0]          rw_i,
    input  logic [N_CH*ADDR_W-1:0]   addr_i,
    input  logic [N_CH*DATA_W-1:0]   wdata_i,
    input  logic [N_CH*BE_W-1:0]     be_n_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [N_CH-1:0]          r_ready_o,
    output logic [N_CH-1:0]          w_finish_o,
    output logic [CW-1:0]            grant_o,
    output logic                     busy_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    input  logic [DATA_W-1:0]        ram_data_i,
    output logic [DATA_W-1:0]        ram_data_o,
    output logic                     ram_data_t_o,
    output logic [BE_W-1:0]          ram_be_n_o,
    output logic                     ram_ce_n_o,
    output logic                     ram_oe_n_o,
    output logic                     ram_we_n_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, HOLD, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_n_q, be_n_d;
    logic [CW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [N_CH-1:0]   r_ready_q, r_ready_d;
    logic [N_CH-1:0]   w_finish_q, w_finish_d;
    logic              busy_q, busy_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              data_t_q, data_t_d;

    logic [N_CH-1:0]   hi_mask, cand, resp_oh;
    logic [CW-1:0]     win;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be_n;

    assign resp_oh = N_CH'(1) << grant_q;

    // Round-robin: prefer requesters at or above the pointer, else wrap to the lowest index.
    always_comb begin
        hi_mask = '0;
        for (int c = 0; c < N_CH; c++)
            hi_mask[c] = (ARB_RR != 0) && (CW'(c) >= ptr_q);
        cand = (|(req_i & hi_mask)) ? (req_i & hi_mask) : req_i;
        win = '0;
        for (int c = N_CH - 1; c >= 0; c--)
            if (cand[c]) win = CW'(c);
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be_n  = '1;
        for (int c = 0; c < N_CH; c++)
            if (win == CW'(c)) begin
                sel_rw    = rw_i[c];
                sel_addr  = addr_i[c*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[c*DATA_W +: DATA_W];
                sel_be_n  = be_n_i[c*BE_W +: BE_W];
            end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_n_d     = be_n_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        rdata_d    = rdata_q;
        r_ready_d  = '0;
        w_finish_d = '0;
        case (state_q)
            IDLE: if (|req_i) begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_CYC);
                grant_d = win;
                ptr_d   = (win == CW'(N_CH - 1)) ? '0 : win + 1'b1;
                rw_d    = sel_rw;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
                be_n_d  = sel_be_n;
            end
            ACCESS: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else if (rw_q) begin
                    state_d   = DONE;
                    rdata_d   = ram_data_i;
                    r_ready_d = resp_oh;
                end else state_d = HOLD;
            HOLD: begin
                state_d    = DONE;
                w_finish_d = resp_oh;
            end
            default: state_d = IDLE;
        endcase
        // Strobes are registered from the next state so they are glitch-free at the pins.
        ce_n_d   = !(state_d == ACCESS || state_d == HOLD);
        oe_n_d   = !(state_d == ACCESS && rw_d);
        we_n_d   = !(state_d == ACCESS && !rw_d);
        data_t_d = (state_d == ACCESS || state_d == HOLD) && !rw_d;
        busy_d   = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_n_q     <= '1;
            grant_q    <= '0;
            ptr_q      <= '0;
            rdata_q    <= '0;
            r_ready_q  <= '0;
            w_finish_q <= '0;
            busy_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            data_t_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_n_q     <= be_n_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            rdata_q    <= rdata_d;
            r_ready_q  <= r_ready_d;
            w_finish_q <= w_finish_d;
            busy_q     <= busy_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            data_t_q   <= data_t_d;
        end
    end

    assign rdata_o      = rdata_q;
    assign r_ready_o    = r_ready_q;
    assign w_finish_o   = w_finish_q;
    assign grant_o      = grant_q;
    assign busy_o       = busy_q;
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = wdata_q;
    assign ram_data_t_o = data_t_q;
    assign ram_be_n_o   = be_n_q;
    assign ram_ce_n_o   = ce_n_q;
    assign ram_oe_n_o   = oe_n_q;
    assign ram_we_n_o   = we_n_q;
endmodule
